skid_buffer_reg: RTL and testbench



---
 rtl/skid_buffer_reg.sv | 87 ++++++++
 tb/tb_skid_buffer_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer_reg.sv
// Two-entry val/rdy skid buffer with every crossing signal registered.
// in_rdy depends only on state and reset, so out_rdy never reaches it combinationally.
module skid_buffer_reg #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic [1:0]         count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [p_nbits-1:0] main_q;
  logic [p_nbits-1:0] main_next;
  logic [p_nbits-1:0] skid_q;
  logic [p_nbits-1:0] skid_next;
  logic               in_fire;
  logic               out_fire;

  assign out_val  = (state != EMPTY);
  assign in_rdy   = (state != FULL) && !reset;
  assign count    = state;
  assign out_msg  = main_q;
  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  // Next-state and data-capture decode; the head only moves when it is consumed.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_next  = in_msg;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_msg;
        end else if (in_fire) begin
          skid_next  = in_msg;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_next  = skid_q;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

`ifndef SYNTHESIS
  a_state_legal: assert property (@(posedge clk) disable iff (reset) state != 2'd3);
  a_in_val_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(in_val));
  a_out_rdy_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(out_rdy));
`endif

endmodule

// File: tb/tb_skid_buffer_reg.sv
// Scoreboard bench for skid_buffer_reg: directed scenarios plus random val/rdy traffic
// checked against a queue-based model of a two-deep FIFO.
module tb_skid_buffer_reg;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic [1:0]  count;

  int checks;
  int failures;
  logic [31:0] model_q[$];
  logic        hold;
  logic [31:0] held_msg;
  logic        acc;

  skid_buffer_reg #(.p_nbits(32)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; acc records whether the offered message was taken.
  task automatic step();
    @(negedge clk);
    acc = in_val && in_rdy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a two-entry FIFO model; occupancy and head come straight from the queue.
  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
      hold = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(model_q.size()));
      chk("out_val", 32'(out_val), 32'(model_q.size() != 0));
      chk("in_rdy", 32'(in_rdy), 32'(model_q.size() < 2));
      if (hold && out_val) chk("held_stable", out_msg, held_msg);
      if (model_q.size() != 0) chk("out_msg_order", out_msg, model_q[0]);
      if (out_val && out_rdy && model_q.size() != 0) void'(model_q.pop_front());
      if (in_val && in_rdy) model_q.push_back(in_msg);
      hold     = out_val && !out_rdy;
      held_msg = out_msg;
    end
  end

  initial begin
    int sent;
    int cyc;
    checks = 0; failures = 0; hold = 1'b0; held_msg = '0; acc = 1'b0;
    reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
    #3;
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("deassert_in_rdy", 32'(in_rdy), 32'd1);
    step();
    chk("idle_out_val", 32'(out_val), 32'd0);

    // Reset pulse mid-cycle from idle
    #2 reset = 1'b1;
    #1;
    chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("postrst_out_val", 32'(out_val), 32'd0);
    chk("postrst_in_rdy", 32'(in_rdy), 32'd1);

    // Streaming at full rate
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_val = 1'b1;
      in_msg = 32'(i);
      chk("stream_in_rdy", 32'(in_rdy), 32'd1);
      step();
      chk("stream_head", out_msg, 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    in_val = 1'b0;
    step();
    chk("stream_drained", 32'(count), 32'd0);

    // Skid fill with downstream stalled
    out_rdy = 1'b0;
    in_val = 1'b1; in_msg = 32'hA;
    step();
    chk("fill_count1", 32'(count), 32'd1);
    in_msg = 32'hB;
    step();
    chk("fill_count2", 32'(count), 32'd2);
    chk("fill_in_rdy", 32'(in_rdy), 32'd0);
    in_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_head", out_msg, 32'hA);
    end

    // Drain from FULL
    out_rdy = 1'b1;
    chk("drain_head_a", out_msg, 32'hA);
    step();
    chk("drain_head_b", out_msg, 32'hB);
    chk("drain_count1", 32'(count), 32'd1);
    chk("drain_in_rdy", 32'(in_rdy), 32'd1);
    step();
    chk("drain_count0", 32'(count), 32'd0);

    // Random val/rdy traffic
    sent = 0; cyc = 0;
    in_val = 1'b0;
    while (sent < 200 && cyc < 4000) begin
      in_val  = ($urandom % 2) == 1;
      in_msg  = $urandom;
      out_rdy = ($urandom % 2) == 1;
      step();
      if (acc) sent++;
      cyc++;
    end
    chk("random_sent", 32'(sent), 32'd200);
    in_val = 1'b0; out_rdy = 1'b1;
    cyc = 0;
    while (model_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("random_drain", 32'(model_q.size()), 32'd0);

    // Reset while FULL discards held messages
    out_rdy = 1'b0;
    in_val = 1'b1; in_msg = 32'h1;
    step();
    in_msg = 32'h2;
    step();
    in_val = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("fullrst_count", 32'(count), 32'd0);
    chk("fullrst_out_val", 32'(out_val), 32'd0);
    chk("fullrst_out_msg", out_msg, 32'd0);
    chk("fullrst_in_rdy", 32'(in_rdy), 32'd0);
    step();
    reset = 1'b0;
    in_val = 1'b1; in_msg = 32'h3; out_rdy = 1'b1;
    step();
    in_val = 1'b0;
    chk("after_rst_val", 32'(out_val), 32'd1);
    chk("after_rst_first", out_msg, 32'h3);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
